sfp_link_manager: RTL and testbench



---
 rtl/sfp_link_manager.sv | 181 ++++++++++++++++++
 tb/tb_sfp_link_manager.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sfp_link_manager.sv
// rtl/sfp_link_manager.sv - per-port SFP+ bring-up, lock supervision and flap counting
module sfp_link_manager #(
  parameter int N_PORTS      = 2,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int DEBOUNCE     = 1024,
  parameter int RETRY_LIMIT  = 3
) (
  input  logic                  clk_156mhz,
  input  logic                  rst_156mhz_n,
  input  logic                  qplllock,
  input  logic                  reset_counter_done,
  input  logic [N_PORTS-1:0]    port_enable,
  input  logic [N_PORTS-1:0]    clear_fail,
  input  logic [N_PORTS-1:0]    sfp_absent,
  input  logic [N_PORTS-1:0]    sfp_tx_fault,
  input  logic [N_PORTS-1:0]    rx_block_lock,
  output logic [N_PORTS-1:0]    sfp_tx_disable,
  output logic [N_PORTS-1:0]    pcs_reset,
  output logic [N_PORTS-1:0]    link_up,
  output logic [N_PORTS-1:0]    port_failed,
  output logic                  all_up,
  output logic [16*N_PORTS-1:0] flap_count
);

  localparam int RW = $clog2(RESET_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    ST_DOWN,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_UP,
    ST_FAILED
  } state_t;

  logic [N_PORTS-1:0] absent_m, absent_s, fault_m, fault_s;
  logic [N_PORTS-1:0] ok;

  // two-flop synchronizers for the module pins; reset to "absent, faulted"
  always_ff @(posedge clk_156mhz or negedge rst_156mhz_n) begin
    if (!rst_156mhz_n) begin
      absent_m <= '1;
      absent_s <= '1;
      fault_m  <= '1;
      fault_s  <= '1;
    end else begin
      absent_m <= sfp_absent;
      absent_s <= absent_m;
      fault_m  <= sfp_tx_fault;
      fault_s  <= fault_m;
    end
  end

  assign ok = {N_PORTS{qplllock & reset_counter_done}} & port_enable & ~absent_s & ~fault_s;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    state_t        state_q, state_d;
    logic [RW-1:0] rst_tmr_q, rst_tmr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] run_q, run_d;  // consecutive lock edges in WAIT_LOCK, loss edges in UP
    logic [3:0]    retry_q, retry_d;
    logic [15:0]   flap_q, flap_d;
    logic          txd_q, pcs_q, up_q, fail_q;

    // next state and counter updates; loss of ok overrides everything but FAILED
    always_comb begin
      state_d   = state_q;
      rst_tmr_d = rst_tmr_q;
      tmo_d     = tmo_q;
      run_d     = run_q;
      retry_d   = retry_q;
      flap_d    = flap_q;
      case (state_q)
        ST_DOWN: begin
          state_d   = ST_RESET;
          rst_tmr_d = RST_LOAD;
        end
        ST_RESET: begin
          if (rst_tmr_q == '0) begin
            state_d = ST_WAIT_LOCK;
            tmo_d   = '0;
            run_d   = '0;
          end else begin
            rst_tmr_d = rst_tmr_q - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          tmo_d = tmo_q + 1'b1;
          run_d = rx_block_lock[g] ? run_q + 1'b1 : '0;
          if (rx_block_lock[g] && run_q == DEB_LAST) begin
            state_d = ST_UP;
            run_d   = '0;
            retry_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAILED;
            end else begin
              state_d   = ST_RESET;
              retry_d   = retry_q + 1'b1;
              rst_tmr_d = RST_LOAD;
            end
          end
        end
        ST_UP: begin
          if (rx_block_lock[g]) begin
            run_d = '0;
          end else if (run_q == DEB_LAST) begin
            state_d = ST_WAIT_LOCK;
            tmo_d   = '0;
            run_d   = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        ST_FAILED: begin
          if (clear_fail[g] || absent_s[g]) begin
            state_d = ST_DOWN;
            retry_d = '0;
          end
        end
        default: state_d = ST_DOWN;
      endcase
      if (state_q != ST_FAILED && !ok[g]) begin
        state_d = ST_DOWN;
        retry_d = retry_q;
      end
      if (state_q == ST_UP && state_d != ST_UP && flap_q != 16'hFFFF) begin
        flap_d = flap_q + 16'd1;
      end
    end

    // state, counters and outputs registered together, outputs decoded from the next state
    always_ff @(posedge clk_156mhz or negedge rst_156mhz_n) begin
      if (!rst_156mhz_n) begin
        state_q   <= ST_DOWN;
        rst_tmr_q <= '0;
        tmo_q     <= '0;
        run_q     <= '0;
        retry_q   <= '0;
        flap_q    <= '0;
        txd_q     <= 1'b1;
        pcs_q     <= 1'b1;
        up_q      <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        rst_tmr_q <= rst_tmr_d;
        tmo_q     <= tmo_d;
        run_q     <= run_d;
        retry_q   <= retry_d;
        flap_q    <= flap_d;
        txd_q     <= (state_d == ST_DOWN) || (state_d == ST_FAILED);
        pcs_q     <= (state_d != ST_WAIT_LOCK) && (state_d != ST_UP);
        up_q      <= (state_d == ST_UP);
        fail_q    <= (state_d == ST_FAILED);
      end
    end

    assign sfp_tx_disable[g]       = txd_q;
    assign pcs_reset[g]            = pcs_q;
    assign link_up[g]              = up_q;
    assign port_failed[g]          = fail_q;
    assign flap_count[16*g +: 16]  = flap_q;
  end

  // aggregate link status, one cycle behind link_up
  always_ff @(posedge clk_156mhz or negedge rst_156mhz_n) begin
    if (!rst_156mhz_n) begin
      all_up <= 1'b0;
    end else begin
      all_up <= &link_up;
    end
  end

endmodule

// File: tb/tb_sfp_link_manager.sv
// tb/tb_sfp_link_manager.sv - randomized scoreboard bench for sfp_link_manager
module tb_sfp_link_manager;

  localparam int NP = 2;
  localparam int RC = 16;
  localparam int LT = 200;
  localparam int DB = 8;
  localparam int RL = 2;

  localparam int P_OFF  = 0;
  localparam int P_RST  = 1;
  localparam int P_WAIT = 2;
  localparam int P_LINK = 3;
  localparam int P_PARK = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             qpll, rcd;
  logic [NP-1:0]    en, clr, absent, fault, lock;
  logic [NP-1:0]    sfp_tx_disable, pcs_reset, link_up, port_failed;
  logic             all_up;
  logic [16*NP-1:0] flap_count;

  always #5 clk = ~clk;

  sfp_link_manager #(
    .N_PORTS(NP), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .DEBOUNCE(DB), .RETRY_LIMIT(RL)
  ) dut (
    .clk_156mhz(clk),
    .rst_156mhz_n(rst_n),
    .qplllock(qpll),
    .reset_counter_done(rcd),
    .port_enable(en),
    .clear_fail(clr),
    .sfp_absent(absent),
    .sfp_tx_fault(fault),
    .rx_block_lock(lock),
    .sfp_tx_disable(sfp_tx_disable),
    .pcs_reset(pcs_reset),
    .link_up(link_up),
    .port_failed(port_failed),
    .all_up(all_up),
    .flap_count(flap_count)
  );

  // reference model state: phase per port plus plain integer counters
  int            ph[NP], rst_left[NP], wait_age[NP], lock_run[NP], loss_run[NP], tries[NP], flaps[NP];
  logic [NP-1:0] abs_m, abs_s, flt_m, flt_s;
  logic          m_allup;
  logic [40:0]   exp_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [40:0] exp_vec();
    logic [NP-1:0] txd, pcs, lu, pf;
    for (int i = 0; i < NP; i++) begin
      txd[i] = (ph[i] == P_OFF) || (ph[i] == P_PARK);
      pcs[i] = (ph[i] != P_WAIT) && (ph[i] != P_LINK);
      lu[i]  = (ph[i] == P_LINK);
      pf[i]  = (ph[i] == P_PARK);
    end
    return {txd, pcs, lu, pf, m_allup, 16'(flaps[1]), 16'(flaps[0])};
  endfunction

  // model: advance one edge and queue the outputs the DUT must show afterwards
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        ph[i] = P_OFF; rst_left[i] = 0; wait_age[i] = 0; lock_run[i] = 0;
        loss_run[i] = 0; tries[i] = 0; flaps[i] = 0;
      end
      abs_m = '1; abs_s = '1; flt_m = '1; flt_s = '1;
      m_allup = 1'b0;
    end else begin
      m_allup = (ph[0] == P_LINK) && (ph[1] == P_LINK);
      for (int i = 0; i < NP; i++) begin
        logic okv;
        int   prev;
        prev = ph[i];
        okv  = qpll && rcd && en[i] && !abs_s[i] && !flt_s[i];
        if (ph[i] != P_PARK && !okv) begin
          ph[i] = P_OFF;
        end else begin
          case (ph[i])
            P_OFF: begin ph[i] = P_RST; rst_left[i] = RC; end
            P_RST: begin
              rst_left[i]--;
              if (rst_left[i] == 0) begin ph[i] = P_WAIT; wait_age[i] = 0; lock_run[i] = 0; end
            end
            P_WAIT: begin
              wait_age[i]++;
              lock_run[i] = lock[i] ? lock_run[i] + 1 : 0;
              if (lock_run[i] == DB) begin
                ph[i] = P_LINK; loss_run[i] = 0; tries[i] = 0;
              end else if (wait_age[i] == LT) begin
                if (tries[i] == RL) ph[i] = P_PARK;
                else begin tries[i]++; ph[i] = P_RST; rst_left[i] = RC; end
              end
            end
            P_LINK: begin
              loss_run[i] = lock[i] ? 0 : loss_run[i] + 1;
              if (loss_run[i] == DB) begin ph[i] = P_WAIT; wait_age[i] = 0; lock_run[i] = 0; end
            end
            default: begin
              if (clr[i] || abs_s[i]) begin ph[i] = P_OFF; tries[i] = 0; end
            end
          endcase
        end
        if (prev == P_LINK && ph[i] != P_LINK && flaps[i] < 65535) flaps[i]++;
      end
      abs_s = abs_m; abs_m = absent;
      flt_s = flt_m; flt_m = fault;
    end
    exp_q.push_back(exp_vec());
  end

  task automatic compare(input string name, input logic [40:0] got, input logic [40:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got txd=%b pcs=%b up=%b failed=%b all_up=%b flaps=%h required txd=%b pcs=%b up=%b failed=%b all_up=%b flaps=%h",
               name, $time, got[40:39], got[38:37], got[36:35], got[34:33], got[32], got[31:0],
               want[40:39], want[38:37], want[36:35], want[34:33], want[32], want[31:0]);
    end
  endtask

  // monitor: pops one expectation per falling clock edge; checks async reset on its own edge
  initial begin
    logic       last_rst;
    logic [40:0] rst_vec;
    rst_vec  = {2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 32'h0};
    last_rst = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n && last_rst) begin
        #1;
        compare("async_reset", {sfp_tx_disable, pcs_reset, link_up, port_failed, all_up, flap_count}, rst_vec);
      end else if (!clk && exp_q.size() > 0) begin
        compare("scoreboard", {sfp_tx_disable, pcs_reset, link_up, port_failed, all_up, flap_count},
                exp_q.pop_front());
      end
      last_rst = rst_n;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stimulus
  initial begin
    rst_n = 1'b0; qpll = 1'b0; rcd = 1'b0; en = '0; clr = '0;
    absent = '1; fault = '1; lock = '0;
    cyc(5);
    rst_n = 1'b1;
    cyc(5);
    // nominal bring-up
    qpll = 1'b1; rcd = 1'b1; en = 2'b11; absent = '0; fault = '0;
    cyc(20);
    lock = 2'b11;
    cyc(20);
    // lock glitch during WAIT_LOCK on port 0
    lock[0] = 1'b0; cyc(8);
    lock[0] = 1'b1; cyc(7);
    lock[0] = 1'b0; cyc(1);
    lock[0] = 1'b1; cyc(12);
    // five full-length drops, then one short drop
    repeat (5) begin lock[0] = 1'b0; cyc(8); lock[0] = 1'b1; cyc(12); end
    lock[0] = 1'b0; cyc(7); lock[0] = 1'b1; cyc(10);
    // random short glitches on both ports
    repeat (20) begin
      lock = ($urandom_range(0, 1) == 0) ? 2'($urandom) : 2'b11;
      cyc($urandom_range(1, 10));
    end
    lock = 2'b11; cyc(30);
    // module removal on port 1
    absent[1] = 1'b1; cyc(10);
    absent[1] = 1'b0; cyc(40);
    // tx fault on port 0 while waiting for lock, then retry exhaustion
    lock[0] = 1'b0; cyc(30);
    fault[0] = 1'b1; cyc(5);
    fault[0] = 1'b0;
    cyc(3 * (LT + RC) + 60);
    clr[0] = 1'b1; cyc(1);
    clr[0] = 1'b0; lock[0] = 1'b1;
    cyc(40);
    // randomized soak
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) lock = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 79) == 0) en = 2'($urandom);
      if ($urandom_range(0, 99) == 0) fault = 2'($urandom);
      if ($urandom_range(0, 99) == 0) absent = ($urandom_range(0, 1) == 0) ? 2'($urandom) : 2'b00;
      clr = ($urandom_range(0, 29) == 0) ? 2'($urandom) : 2'b00;
      cyc(1);
    end
    en = 2'b11; absent = '0; fault = '0; lock = 2'b11; clr = 2'b11;
    cyc(1);
    clr = '0;
    cyc(60);
    // shared PLL loss and relock
    qpll = 1'b0; cyc(10);
    qpll = 1'b1; cyc(60);
    // reset asserted while both ports are in RESET
    qpll = 1'b0; cyc(5);
    qpll = 1'b1; cyc(8);
    #6;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
